// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that shares the register file write port between the ALU (A)
// and the load unit (B). It also keeps a busy scoreboard for read-after-write hazard checks.
module regfile_write_arbiter #(
    parameter int DATA_W      = 16,
    parameter int NUM_REGS    = 16,
    parameter int ADDR_W      = 4,
    parameter int ZERO_REG_RO = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a_valid,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_data,
    output logic                a_ready,
    input  logic                b_valid,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_data,
    output logic                b_ready,
    input  logic                rsv_valid,
    input  logic [ADDR_W-1:0]   rsv_addr,
    input  logic [ADDR_W-1:0]   chk1_addr,
    input  logic [ADDR_W-1:0]   chk2_addr,
    output logic                chk1_busy,
    output logic                chk2_busy,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [15:0]         rf_write_code,
    output logic                rf_w_flag,
    output logic [DATA_W-1:0]   rf_w_data,
    output logic [7:0]          conflict_cnt
);

    typedef enum logic {
        GRANT_A,
        GRANT_B
    } grant_t;

    grant_t              last_grant;
    logic                xfer;
    logic [ADDR_W-1:0]   xfer_addr;
    logic [DATA_W-1:0]   xfer_data;
    logic                xfer_to_zero;
    logic                rsv_to_zero;
    logic [NUM_REGS-1:0] busy_next;

    assign a_ready = a_valid && (!b_valid || last_grant == GRANT_B);
    assign b_ready = b_valid && (!a_valid || last_grant == GRANT_A);
    assign xfer      = a_ready || b_ready;
    assign xfer_addr = a_ready ? a_addr : b_addr;
    assign xfer_data = a_ready ? a_data : b_data;

    assign xfer_to_zero = (ZERO_REG_RO != 0) && (xfer_addr == '0);
    assign rsv_to_zero  = (ZERO_REG_RO != 0) && (rsv_addr == '0);

    // Hazard checks see only the registered scoreboard; same-cycle clears are not forwarded.
    assign chk1_busy = busy_vec[chk1_addr];
    assign chk2_busy = busy_vec[chk2_addr];

    // Set is applied after clear so a fresh reservation outlives the retiring write.
    always_comb begin
        busy_next = busy_vec;
        if (xfer) begin
            busy_next[xfer_addr] = 1'b0;
        end
        if (rsv_valid && !rsv_to_zero) begin
            busy_next[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_w_flag     <= 1'b0;
            rf_write_code <= '0;
            rf_w_data     <= '0;
            busy_vec      <= '0;
            conflict_cnt  <= '0;
            last_grant    <= GRANT_B;
        end else begin
            rf_w_flag <= xfer && !xfer_to_zero;
            if (xfer && !xfer_to_zero) begin
                rf_write_code <= {{(16-ADDR_W){1'b0}}, xfer_addr};
                rf_w_data     <= xfer_data;
            end
            if (a_ready) begin
                last_grant <= GRANT_A;
            end else if (b_ready) begin
                last_grant <= GRANT_B;
            end
            busy_vec <= busy_next;
            if (a_valid && b_valid && conflict_cnt != 8'hFF) begin
                conflict_cnt <= conflict_cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the register file's single write port between two writeback requesters: A (ALU result) and B (memory load). Uses valid/ready handshakes with round-robin arbitration and drives a registered write stage into the register file (write_code / w_flag / w_data). Keeps a 16-entry busy scoreboard so decode logic can detect read-after-write hazards on the register file's two read ports.

Parameters:
DATA_W, 16, width of write data
NUM_REGS, 16, number of architectural registers
ADDR_W, 4, register index width (log2 NUM_REGS)
ZERO_REG_RO, 1, when 1, writes to register 0 are accepted but never reach the register file

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high
a_valid  input  1  requester A has a write
a_addr  input  ADDR_W  A destination register
a_data  input  DATA_W  A write data
a_ready  output  1  A transfer accepted this cycle
b_valid  input  1  requester B has a write
b_addr  input  ADDR_W  B destination register
b_data  input  DATA_W  B write data
b_ready  output  1  B transfer accepted this cycle
rsv_valid  input  1  issue stage reserves a destination
rsv_addr  input  ADDR_W  reserved register index
chk1_addr  input  ADDR_W  read-port-1 register to hazard-check
chk2_addr  input  ADDR_W  read-port-2 register to hazard-check
chk1_busy  output  1  busy_vec[chk1_addr]
chk2_busy  output  1  busy_vec[chk2_addr]
busy_vec  output  NUM_REGS  scoreboard, bit i = write to reg i outstanding
rf_write_code  output  16  register file write index, zero-extended from ADDR_W
rf_w_flag  output  1  register file write enable
rf_w_data  output  DATA_W  register file write data
conflict_cnt  output  8  saturating count of cycles with both requesters valid

Behaviour:
- Reset (clk edge with reset=1): rf_w_flag=0, rf_write_code=0, rf_w_data=0, busy_vec=0, conflict_cnt=0, last_grant=B so A wins the first conflict. Any write held in the output stage is dropped, not committed.
- Transfer: X transfers when X_valid && X_ready. Ready is combinational and there is no backpressure from the register file.
- Grant rules: a_ready = a_valid && (!b_valid || last_grant==B); b_ready = b_valid && (!a_valid || last_grant==A).
- At most one transfer per cycle. last_grant updates only on a transfer.
- Output stage: on the edge after a transfer, rf_w_flag=1, rf_write_code={0,addr}, rf_w_data=data. With no transfer, rf_w_flag=0 and code/data hold their last values. The register file commits on the following edge.
- Register 0: if ZERO_REG_RO=1 and addr==0, the transfer still completes but rf_w_flag stays 0.
- Scoreboard set: on rsv_valid, busy_vec[rsv_addr] is set at the edge.
- Scoreboard clear: a transfer to register r clears busy_vec[r] at the same edge.
- Simultaneous set and clear on the same r: set wins, because a new producer is now outstanding.
- Register 0 is never set when ZERO_REG_RO=1.
- A transfer to a register that is not busy is legal; its busy bit stays 0.
- chk*_busy are combinational from the registered busy_vec. A clear happening this cycle is not forwarded.
- conflict_cnt increments on every cycle with a_valid && b_valid and saturates at 255.
- Requesters must hold valid/addr/data stable until ready; the arbiter does not check this.

Test Plan:
- Single A write: a_valid=1, addr=5, data=16'hBEEF for one cycle → a_ready=1 that cycle; next cycle rf_w_flag=1, rf_write_code=16'h0005, rf_w_data=16'hBEEF; following cycle rf_w_flag=0.
- Conflict round-robin: A (addr 1) and B (addr 2) held valid from reset → grants A, B, A, B on consecutive cycles; rf_write_code sequence 1,2,1,2; conflict_cnt increments each cycle and saturates at 255 after 255 conflict cycles.
- Scoreboard: rsv_valid addr=7 → busy_vec[7]=1, chk1_addr=7 gives chk1_busy=1; B writes addr 7 → busy_vec[7]=0 on the transfer edge; rsv and transfer on addr 3 in the same cycle → busy_vec[3]=1.
- Zero register: A writes addr 0, data 16'h1234 → a_ready=1, rf_w_flag stays 0; rsv_valid addr 0 → busy_vec[0]=0.
- Reset mid-operation: transfer accepted, then reset=1 on the next edge → rf_w_flag=0, busy_vec=0, conflict_cnt=0; the next conflict grants A first.
